// File: rtl/vme_slave_responder.sv
// VME A24 responder for the local RAM window. It decodes the access, drives the local
// RAM strobes and data buffer controls, and answers with DTACK* or BERR*.
module vme_slave_responder #(
   parameter logic [7:0] BASE_ADDR = 8'hE0,
   parameter logic [5:0] AM_SUPER  = 6'h3D,
   parameter logic [5:0] AM_USER   = 6'h39,
   parameter logic [7:0] TIMEOUT   = 8'd64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       vme_as,
   input  logic [1:0] vme_ds,
   input  logic       vme_lword,
   input  logic       vme_write,
   input  logic       vme_iack,
   input  logic [5:0] vme_address_mod,
   input  logic [7:0] vme_address_high,
   input  logic       vme_address_a1,
   output logic       vme_dtack,
   output logic       vme_berr,
   output logic       local_request,
   output logic       local_write,
   output logic [3:0] local_ds,
   input  logic       local_ack,
   output logic       data_buf_oe,
   output logic       data_buf_dir,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_ACCESS,
      ST_DTACK,
      ST_BERR,
      ST_WAIT_REL
   } state_t;

   state_t     state;
   logic [7:0] counter;
   logic       as_meta, as_s;
   logic [1:0] ds_meta, ds_s;

   logic       select_hit;
   logic       bad_size;
   logic [3:0] lanes;

   // Qualifiers are read raw: by the time DECODE runs they have been stable for two clocks.
   assign select_hit = vme_iack && (vme_address_high == BASE_ADDR) &&
                       ((vme_address_mod == AM_SUPER) || (vme_address_mod == AM_USER));

   assign bad_size = vme_lword ? (ds_s == 2'b11)
                               : (vme_address_a1 || (ds_s != 2'b00));

   always_comb begin
      lanes = 4'b0000;
      if (vme_lword) begin
         lanes = vme_address_a1 ? {2'b11, ds_s} : {ds_s, 2'b11};
      end
   end

   // NOTE: one clocked block, non-blocking only; every output is a register that is
   // updated on the transition into the state that owns it.
   always_ff @(posedge clock) begin
      if (!reset) begin
         as_meta       <= 1'b1;
         as_s          <= 1'b1;
         ds_meta       <= 2'b11;
         ds_s          <= 2'b11;
         state         <= ST_IDLE;
         counter       <= 8'd0;
         vme_dtack     <= 1'b1;
         vme_berr      <= 1'b1;
         local_request <= 1'b1;
         local_write   <= 1'b1;
         local_ds      <= 4'b1111;
         data_buf_oe   <= 1'b1;
         data_buf_dir  <= 1'b0;
         busy          <= 1'b0;
      end else begin
         as_meta <= vme_as;
         as_s    <= as_meta;
         ds_meta <= vme_ds;
         ds_s    <= ds_meta;

         case (state)
            ST_IDLE: begin
               if (!as_s && (ds_s != 2'b11)) begin
                  state <= ST_DECODE;
                  busy  <= 1'b1;
               end
            end

            ST_DECODE: begin
               if (!select_hit) begin
                  state <= ST_WAIT_REL;
               end else if (bad_size) begin
                  state    <= ST_BERR;
                  vme_berr <= 1'b0;
               end else begin
                  state         <= ST_ACCESS;
                  counter       <= 8'd0;
                  local_request <= 1'b0;
                  local_ds      <= lanes;
                  local_write   <= vme_write;
                  data_buf_oe   <= 1'b0;
                  data_buf_dir  <= vme_write;
               end
            end

            ST_ACCESS: begin
               counter <= counter + 8'd1;
               // Ack is tested first so it wins over a timeout on the same clock.
               if (!local_ack) begin
                  state         <= ST_DTACK;
                  vme_dtack     <= 1'b0;
                  local_request <= 1'b1;
                  local_ds      <= 4'b1111;
                  local_write   <= 1'b1;
               end else if (counter == 8'(TIMEOUT - 8'd1)) begin
                  state         <= ST_BERR;
                  vme_berr      <= 1'b0;
                  local_request <= 1'b1;
                  local_ds      <= 4'b1111;
                  local_write   <= 1'b1;
                  data_buf_oe   <= 1'b1;
                  data_buf_dir  <= 1'b0;
               end else if (ds_s == 2'b11) begin
                  state         <= ST_WAIT_REL;
                  local_request <= 1'b1;
                  local_ds      <= 4'b1111;
                  local_write   <= 1'b1;
                  data_buf_oe   <= 1'b1;
                  data_buf_dir  <= 1'b0;
               end
            end

            ST_DTACK: begin
               if (ds_s == 2'b11) begin
                  state        <= ST_WAIT_REL;
                  vme_dtack    <= 1'b1;
                  data_buf_oe  <= 1'b1;
                  data_buf_dir <= 1'b0;
               end
            end

            ST_BERR: begin
               if (ds_s == 2'b11) begin
                  state    <= ST_WAIT_REL;
                  vme_berr <= 1'b1;
               end
            end

            ST_WAIT_REL: begin
               if (as_s) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
